// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - trace capture FIFO with sticky overflow and saturating drop counter
// Writes that arrive while full are discarded and counted; storage is a simple dual-port RAM.
module trace_fifo #(
  parameter int WIDTH        = 40,
  parameter int DEPTH_LOG2   = 11,
  parameter int AFULL_THRESH = 2**DEPTH_LOG2 - 16,
  parameter int DROP_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  ine,
  input  logic [WIDTH-1:0]      in,
  input  logic                  adv,
  output logic [WIDTH-1:0]      out,
  output logic                  oute,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count,
  input  logic                  drop_clr
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wpos;
  logic [PW-1:0]    rpos;
  logic             wr_en;
  logic             rd_en;
  logic             drop;

  // Status is derived purely from the registered pointers; the MSB disambiguates full from empty.
  assign level       = wpos - rpos;
  assign full        = (level == PW'(DEPTH));
  assign almost_full = (32'(level) >= 32'(AFULL_THRESH));
  assign oute        = (wpos != rpos);

  assign wr_en = ine && !full && !flush;
  assign rd_en = adv && oute && !flush;
  assign drop  = ine && full && !flush;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wpos[DEPTH_LOG2-1:0]] <= in;
    end
  end

  assign out = mem[rpos[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wpos <= '0;
      rpos <= '0;
    end else if (flush) begin
      wpos <= '0;
      rpos <= '0;
    end else begin
      if (wr_en) begin
        wpos <= wpos + PW'(1);
      end
      if (rd_en) begin
        rpos <= rpos + PW'(1);
      end
    end
  end

  // A clear coinciding with a drop still records that drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop_clr) begin
      overflow   <= drop;
      drop_count <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trace_fifo.sv
// tb/tb_trace_fifo.sv - scoreboard testbench for trace_fifo
// Reference model tracks occupancy as an integer and contents as a queue.
module tb_trace_fifo;

  localparam int WIDTH = 40;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int DW    = 4;
  localparam int DMAX  = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             ine = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             adv = 1'b0;
  logic             drop_clr = 1'b0;
  logic [WIDTH-1:0] out;
  logic             oute;
  logic             full;
  logic             almost_full;
  logic [DL2:0]     level;
  logic             overflow;
  logic [DW-1:0]    drop_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb[$];
  int mlevel = 0;
  int mdrops = 0;
  int movf   = 0;

  trace_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2), .AFULL_THRESH(AFT), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ine(ine), .in(din), .adv(adv),
    .out(out), .oute(oute), .full(full), .almost_full(almost_full), .level(level),
    .overflow(overflow), .drop_count(drop_count), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated on every rising edge from the inputs presented before it.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mlevel = 0;
        mdrops = 0;
        movf   = 0;
        sb.delete();
      end else if (flush) begin
        mlevel = 0;
        sb.delete();
        if (drop_clr) begin
          mdrops = 0;
          movf   = 0;
        end
      end else begin
        automatic bit d  = ine && (mlevel == DEPTH);
        automatic bit wr = ine && (mlevel < DEPTH);
        automatic bit rd = adv && (mlevel > 0);
        if (wr) sb.push_back(din);
        mlevel = mlevel + int'(wr) - int'(rd);
        if (drop_clr) begin
          mdrops = d ? 1 : 0;
          movf   = d ? 1 : 0;
        end else if (d) begin
          movf = 1;
          if (mdrops < DMAX) mdrops++;
        end
      end
    end
  end

  // Monitor: compares status and head-of-queue, and retires entries on accepted pops.
  always @(negedge clk) begin
    if (!reset) begin
      chk("level", 64'(level), 64'(mlevel));
      chk("oute", 64'(oute), 64'(mlevel > 0));
      chk("full", 64'(full), 64'(mlevel == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(mlevel >= AFT));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("drop_count", 64'(drop_count), 64'(mdrops));
      if (mlevel > 0 && sb.size() > 0) begin
        chk("out", 64'(out), 64'(sb[0]));
        if (adv && !flush) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic i_ine, input logic [WIDTH-1:0] d, input logic i_adv,
                     input logic fl, input logic dc);
    ine = i_ine; din = d; adv = i_adv; flush = fl; drop_clr = dc;
    @(posedge clk);
    #2;
    ine = 1'b0; adv = 1'b0; flush = 1'b0; drop_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_oute", 64'(oute), 64'd0);
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;

    // Fill 1..8 then drain in order
    for (int i = 1; i <= 8; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_oute", 64'(oute), 64'd0);

    // Write against full with simultaneous pop is dropped
    for (int i = 1; i <= 8; i++) cyc(1'b1, WIDTH'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, WIDTH'(8'hAA), 1'b1, 1'b0, 1'b0);
    chk("fullpop_level", 64'(level), 64'd7);
    chk("fullpop_drop", 64'(drop_count), 64'd1);
    chk("fullpop_ovf", 64'(overflow), 64'd1);

    // Saturation, then clear while still dropping
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, WIDTH'(8'h19), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    chk("sat_drop", 64'(drop_count), 64'd15);
    cyc(1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_drop", 64'(drop_count), 64'd1);
    chk("clr_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Streaming through pointer wrap
    cyc(1'b1, WIDTH'(32'h100), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) cyc(1'b1, WIDTH'(32'h100 + i), 1'b1, 1'b0, 1'b0);
    chk("stream_level", 64'(level), 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush overrides write/pop and does not count a drop
    for (int i = 0; i < 5; i++) cyc(1'b1, WIDTH'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, WIDTH'(8'h77), 1'b1, 1'b1, 1'b0);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_oute", 64'(oute), 64'd0);
    chk("flush_drop", 64'(drop_count), 64'd1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) cyc(1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("areset_oute", 64'(oute), 64'd0);
    chk("areset_level", 64'(level), 64'd0);
    chk("areset_ovf", 64'(overflow), 64'd0);
    cyc(1'b1, WIDTH'(8'hEE), 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk); #2;
    cyc(1'b1, WIDTH'(3), 1'b0, 1'b0, 1'b0);
    chk("post_reset_out", 64'(out), 64'd3);
    chk("post_reset_level", 64'(level), 64'd1);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      automatic int phase = (i / 250) % 3;
      automatic logic w = ($urandom_range(99) < (phase == 0 ? 70 : (phase == 1 ? 30 : 50)));
      automatic logic a = ($urandom_range(99) < (phase == 0 ? 30 : (phase == 1 ? 70 : 50)));
      automatic logic f = ($urandom_range(99) < 2);
      automatic logic c = ($urandom_range(99) < 3);
      cyc(w, {8'($urandom), $urandom}, a, f, c);
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_fifo.md
TRACE_FIFO -- requirements
Module: trace_fifo

Interface
REQ-001 Parameter WIDTH, 40, data word width in bits.
REQ-002 Parameter DEPTH_LOG2, 11, log2 of entry count; DEPTH = 2**DEPTH_LOG2.
REQ-003 Parameter AFULL_THRESH, 2**DEPTH_LOG2 - 16, level at or above which almost_full asserts.
REQ-004 Parameter DROP_W, 16, width of the saturating drop counter.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 flush  in  1  synchronous pointer clear.
REQ-008 ine  in  1  write request.
REQ-009 in  in  WIDTH  write data.
REQ-010 adv  in  1  consumer pops head entry.
REQ-011 out  out  WIDTH  head entry.
REQ-012 oute  out  1  out valid (FIFO non-empty).
REQ-013 full  out  1  level == DEPTH.
REQ-014 almost_full  out  1  level >= AFULL_THRESH.
REQ-015 level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-016 overflow  out  1  sticky: one or more writes dropped since last clear.
REQ-017 drop_count  out  DROP_W  dropped-write count, saturating at all-ones.
REQ-018 drop_clr  in  1  synchronous clear of overflow and drop_count.

Function
REQ-019 Pointers wpos/rpos SHALL be DEPTH_LOG2+1 bits; the low DEPTH_LOG2 bits index storage; the MSB is the wrap bit; increments wrap modulo 2**(DEPTH_LOG2+1).
REQ-020 level SHALL equal (wpos - rpos) modulo 2**(DEPTH_LOG2+1); full SHALL be (level == DEPTH); oute SHALL be (wpos != rpos); all combinational from registered pointers.
REQ-021 Write accepted iff ine && !full && !flush: mem[wpos] <= in, wpos increments; 1-cycle latency to oute.
REQ-022 Write while full SHALL be decided on pre-edge full, even with a same-cycle pop; the word is discarded.
REQ-023 Pop accepted iff adv && oute && !flush: rpos increments; adv while !oute SHALL be ignored.
REQ-024 Simultaneous accepted write and pop SHALL leave level unchanged.
REQ-025 out SHALL be a combinational read of mem[rpos]; value is don't-care while oute=0.
REQ-026 Dropped write (ine && full && !flush) SHALL set overflow and increment drop_count by 1, holding at 2**DROP_W-1.
REQ-027 drop_clr SHALL clear overflow and drop_count at next edge; a drop in the same cycle SHALL yield overflow=1, drop_count=1.
REQ-028 flush SHALL set wpos=rpos=0 at next edge, overriding same-cycle write/pop; ine during flush SHALL NOT count as a drop; overflow/drop_count unaffected.
REQ-029 Storage SHALL be inferable as a simple dual-port RAM; storage contents SHALL NOT be reset.

Reset
REQ-030 reset assertion SHALL immediately force wpos=0, rpos=0, overflow=0, drop_count=0, hence oute=0, full=0, almost_full=0 (given AFULL_THRESH>0), level=0, without a clock edge.
REQ-031 While reset is high, ine/adv/flush/drop_clr SHALL have no effect; operation resumes at the first rising edge after deassertion.
REQ-032 reset mid-operation SHALL discard all buffered entries; no stale entry SHALL appear on oute afterwards.

Verification (DEPTH_LOG2=3, AFULL_THRESH=6, DROP_W=4 unless stated)
REQ-033 Write 0x1..0x8 on consecutive cycles, no adv -> level 1..8, almost_full from level 6, full after 8th; then pop 8 -> out 0x1..0x8 in order, oute=0 after.
REQ-034 Full FIFO, ine=1 and adv=1 same cycle with in=0xAA -> pop accepted, 0xAA dropped, level=7, overflow=1, drop_count=1.
REQ-035 Full FIFO, ine held 20 cycles -> drop_count saturates at 15; drop_clr with ine still high -> drop_count=1, overflow=1.
REQ-036 Stream 20 words with write and pop every cycle after first -> level stays 1, pointers wrap twice, out sequence matches input exactly.
REQ-037 Level 5, assert flush with ine=1, adv=1 -> next cycle level=0, oute=0, drop_count unchanged.
REQ-038 Level 4, assert reset between edges -> oute=0, level=0 immediately; after deassert, write 0x3 -> out=0x3, level=1.
